// File: rtl/dma_if_desc_split_rd.sv
// dma_if_desc_split_rd
// Read-descriptor splitter that sits in front of one input port of the DMA read mux.
// It accepts one client read descriptor and breaks it into chunks that never cross a
// MAX_CHUNK_LEN-aligned DMA address boundary. The chunks are issued in order, with at most
// MAX_OUTSTANDING of them in flight. Chunk completions are counted, and a single aggregated
// status carrying the client tag is returned once every chunk has completed.
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   s_axis_desc_*                  client read descriptor in (valid/ready)
//   m_axis_desc_*                  chunk descriptor out toward the mux (valid/ready)
//   s_axis_desc_status_*           per-chunk completion status in (valid only)
//   m_axis_desc_status_*           aggregated completion status out (1-cycle pulse)
module dma_if_desc_split_rd #(
  parameter int DMA_ADDR_WIDTH  = 64,
  parameter int RAM_SEL_WIDTH   = 2,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  parameter int M_TAG_WIDTH     = 4,
  parameter int MAX_CHUNK_LEN   = 4096,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DMA_ADDR_WIDTH-1:0] s_axis_desc_dma_addr,
  input  logic [RAM_SEL_WIDTH-1:0]  s_axis_desc_ram_sel,
  input  logic [RAM_ADDR_WIDTH-1:0] s_axis_desc_ram_addr,
  input  logic [LEN_WIDTH-1:0]      s_axis_desc_len,
  input  logic [TAG_WIDTH-1:0]      s_axis_desc_tag,
  input  logic                      s_axis_desc_valid,
  output logic                      s_axis_desc_ready,
  output logic [DMA_ADDR_WIDTH-1:0] m_axis_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]  m_axis_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0] m_axis_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
  output logic [M_TAG_WIDTH-1:0]    m_axis_desc_tag,
  output logic                      m_axis_desc_valid,
  input  logic                      m_axis_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]    s_axis_desc_status_tag,
  input  logic [3:0]                s_axis_desc_status_error,
  input  logic                      s_axis_desc_status_valid,
  output logic [TAG_WIDTH-1:0]      m_axis_desc_status_tag,
  output logic [3:0]                m_axis_desc_status_error,
  output logic                      m_axis_desc_status_valid
);

  localparam int OFFS_W = $clog2(MAX_CHUNK_LEN);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_CHUNK_LEN);
  localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    STATUS = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;

  logic [DMA_ADDR_WIDTH-1:0] r_dmaAddr;
  logic [RAM_SEL_WIDTH-1:0]  r_ramSel;
  logic [RAM_ADDR_WIDTH-1:0] r_ramAddr;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic [LEN_WIDTH-1:0]      r_chunkLen;
  logic [M_TAG_WIDTH-1:0]    r_idx;
  logic [TAG_WIDTH-1:0]      r_tag;
  logic [3:0]                r_errSave;
  logic [CNT_W-1:0]          r_outstanding;
  logic                      r_sReady;
  logic                      r_mValid;
  logic                      r_statusValid;

  logic                      w_accept;
  logic                      w_chunkHs;
  logic                      w_lastChunk;
  logic                      w_statusHit;
  logic [CNT_W-1:0]          w_outstandingNext;
  logic [DMA_ADDR_WIDTH-1:0] w_nextAddr;
  logic [LEN_WIDTH-1:0]      w_nextRem;
  logic [LEN_WIDTH-1:0]      w_nextChunkLen;
  logic [LEN_WIDTH-1:0]      w_acceptChunkLen;

  // Completion tags are not checked: completions return in issue order, so only the count matters.
  logic                      w_unusedStatusTag;
  assign w_unusedStatusTag = ^s_axis_desc_status_tag;

  // Chunk length is the smaller of the bytes left and the distance to the next aligned boundary.
  function automatic logic [LEN_WIDTH-1:0] chunkLen(input logic [OFFS_W-1:0]    offs,
                                                    input logic [LEN_WIDTH-1:0] rem);
    logic [LEN_WIDTH-1:0] toBoundary;
    toBoundary = MAX_LEN - LEN_WIDTH'(offs);
    return (rem < toBoundary) ? rem : toBoundary;
  endfunction

  // Handshake decode, outstanding-count update, next chunk and next state.
  always_comb begin
    w_accept    = s_axis_desc_valid && r_sReady;
    w_chunkHs   = r_mValid && m_axis_desc_ready;
    w_lastChunk = w_chunkHs && (r_chunkLen == r_rem);
    // A completion that arrives with nothing in flight is stale and must not underflow the count.
    w_statusHit = s_axis_desc_status_valid && (r_outstanding != '0);

    w_outstandingNext = r_outstanding;
    if (w_chunkHs && !w_statusHit) begin
      w_outstandingNext = r_outstanding + 1'b1;
    end else if (!w_chunkHs && w_statusHit) begin
      w_outstandingNext = r_outstanding - 1'b1;
    end

    w_nextAddr       = r_dmaAddr + DMA_ADDR_WIDTH'(r_chunkLen);
    w_nextRem        = r_rem - r_chunkLen;
    w_nextChunkLen   = chunkLen(w_nextAddr[OFFS_W-1:0], w_nextRem);
    w_acceptChunkLen = chunkLen(s_axis_desc_dma_addr[OFFS_W-1:0], s_axis_desc_len);

    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (s_axis_desc_len == '0) ? STATUS : ISSUE;
        end
      end
      ISSUE: begin
        if (w_lastChunk) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        // Also reached when the final completion coincides with the final chunk handshake.
        if (r_outstanding == '0) begin
          w_nextState = STATUS;
        end
      end
      STATUS: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register plus the registered handshake/status strobes, all derived from the next state.
  // Valid is withheld only while the in-flight limit is reached; since the count can grow only
  // through a handshake, a presented chunk is never withdrawn before it is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_outstanding <= '0;
      r_sReady      <= 1'b0;
      r_mValid      <= 1'b0;
      r_statusValid <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_outstanding <= w_outstandingNext;
      r_sReady      <= (w_nextState == IDLE);
      r_mValid      <= (w_nextState == ISSUE) && (w_outstandingNext < MAX_CNT);
      r_statusValid <= (w_nextState == STATUS);
    end
  end

  // Descriptor datapath: load on accept, advance to the next chunk on each chunk handshake,
  // and remember the first nonzero completion error of the current descriptor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dmaAddr  <= '0;
      r_ramSel   <= '0;
      r_ramAddr  <= '0;
      r_rem      <= '0;
      r_chunkLen <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_errSave  <= '0;
    end else begin
      if (w_statusHit && (r_errSave == 4'd0) && (s_axis_desc_status_error != 4'd0)) begin
        r_errSave <= s_axis_desc_status_error;
      end
      if (w_accept) begin
        r_dmaAddr  <= s_axis_desc_dma_addr;
        r_ramSel   <= s_axis_desc_ram_sel;
        r_ramAddr  <= s_axis_desc_ram_addr;
        r_rem      <= s_axis_desc_len;
        r_chunkLen <= w_acceptChunkLen;
        r_idx      <= '0;
        r_tag      <= s_axis_desc_tag;
        r_errSave  <= 4'd0;
      end else if (w_chunkHs) begin
        r_dmaAddr  <= w_nextAddr;
        r_ramAddr  <= r_ramAddr + RAM_ADDR_WIDTH'(r_chunkLen);
        r_rem      <= w_nextRem;
        r_chunkLen <= w_nextChunkLen;
        r_idx      <= r_idx + 1'b1;
      end
    end
  end

  assign s_axis_desc_ready        = r_sReady;
  assign m_axis_desc_dma_addr     = r_dmaAddr;
  assign m_axis_desc_ram_sel      = r_ramSel;
  assign m_axis_desc_ram_addr     = r_ramAddr;
  assign m_axis_desc_len          = r_chunkLen;
  assign m_axis_desc_tag          = r_idx;
  assign m_axis_desc_valid        = r_mValid;
  assign m_axis_desc_status_tag   = r_tag;
  assign m_axis_desc_status_error = r_errSave;
  assign m_axis_desc_status_valid = r_statusValid;

endmodule

// File: tb/tb_dma_if_desc_split_rd.sv
// tb_dma_if_desc_split_rd
// Directed self-checking bench for dma_if_desc_split_rd with default parameters
// (64-bit DMA address, 4096-byte chunks, 8 chunks in flight). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_dma_if_desc_split_rd;

  logic        clk;
  logic        rst;
  logic [63:0] sAddr;
  logic [1:0]  sRamSel;
  logic [15:0] sRamAddr;
  logic [15:0] sLen;
  logic [7:0]  sTag;
  logic        sValid;
  logic        sReady;
  logic [63:0] mAddr;
  logic [1:0]  mRamSel;
  logic [15:0] mRamAddr;
  logic [15:0] mLen;
  logic [3:0]  mTag;
  logic        mValid;
  logic        mReady;
  logic [3:0]  stTagIn;
  logic [3:0]  stErrIn;
  logic        stValidIn;
  logic [7:0]  outStTag;
  logic [3:0]  outStErr;
  logic        outStValid;

  int checks;
  int errors;

  dma_if_desc_split_rd dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_desc_dma_addr     (sAddr),
    .s_axis_desc_ram_sel      (sRamSel),
    .s_axis_desc_ram_addr     (sRamAddr),
    .s_axis_desc_len          (sLen),
    .s_axis_desc_tag          (sTag),
    .s_axis_desc_valid        (sValid),
    .s_axis_desc_ready        (sReady),
    .m_axis_desc_dma_addr     (mAddr),
    .m_axis_desc_ram_sel      (mRamSel),
    .m_axis_desc_ram_addr     (mRamAddr),
    .m_axis_desc_len          (mLen),
    .m_axis_desc_tag          (mTag),
    .m_axis_desc_valid        (mValid),
    .m_axis_desc_ready        (mReady),
    .s_axis_desc_status_tag   (stTagIn),
    .s_axis_desc_status_error (stErrIn),
    .s_axis_desc_status_valid (stValidIn),
    .m_axis_desc_status_tag   (outStTag),
    .m_axis_desc_status_error (outStErr),
    .m_axis_desc_status_valid (outStValid)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the flow above stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer a client descriptor starting at a falling edge; returns on the falling edge after it is taken.
  task automatic applyDesc(input logic [63:0] addr, input logic [1:0] sel, input logic [15:0] ramAddr,
                           input logic [15:0] len, input logic [7:0] tag);
    int waitCycles;
    sAddr = addr; sRamSel = sel; sRamAddr = ramAddr; sLen = len; sTag = tag; sValid = 1'b1;
    waitCycles = 0;
    while (sReady !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++;
    if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL desc_accept_timeout: got ready=%0b expected 1", sReady); end
    @(negedge clk);
    sValid = 1'b0;
  endtask

  // Present one chunk completion for a single cycle.
  task automatic applyStatus(input logic [3:0] err);
    stValidIn = 1'b1; stErrIn = err;
    @(negedge clk);
    stValidIn = 1'b0; stErrIn = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sAddr = '0; sRamSel = '0; sRamAddr = '0; sLen = '0; sTag = '0; sValid = 1'b0;
    mReady = 1'b0; stTagIn = '0; stErrIn = '0; stValidIn = 1'b0;
    @(negedge clk);
    checks++; if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_sready: got %0b expected 0", sReady); end
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mvalid: got %0b expected 0", mValid); end
    checks++; if (outStValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stvalid: got %0b expected 0", outStValid); end
    checks++; if (mAddr !== 64'd0 || mLen !== 16'd0 || outStTag !== 8'd0) begin errors++; $display("[TB] FAIL rst_payload: got addr=%0h len=%0h tag=%0h expected 0", mAddr, mLen, outStTag); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %0b expected 1", sReady); end
  endtask

  task automatic test_single_chunk();
    applyDesc(64'h1000, 2'd1, 16'h0100, 16'd4096, 8'hA1);
    checks++; if (mValid !== 1'b1 || mAddr !== 64'h1000 || mLen !== 16'd4096 || mTag !== 4'd0) begin errors++; $display("[TB] FAIL single_chunk: got v=%0b addr=%0h len=%0h tag=%0h expected 1/1000/1000/0", mValid, mAddr, mLen, mTag); end
    checks++; if (mRamAddr !== 16'h0100 || mRamSel !== 2'd1 || sReady !== 1'b0) begin errors++; $display("[TB] FAIL single_ram: got ram=%0h sel=%0h ready=%0b expected 100/1/0", mRamAddr, mRamSel, sReady); end
    mReady = 1'b1;
    @(negedge clk);
    mReady = 1'b0;
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL single_after_hs: got %0b expected 0", mValid); end
    applyStatus(4'd0);
    checks++; if (outStValid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_status: got %0b expected 0", outStValid); end
    @(negedge clk);
    checks++; if (outStValid !== 1'b1 || outStTag !== 8'hA1 || outStErr !== 4'd0) begin errors++; $display("[TB] FAIL single_status: got v=%0b tag=%0h err=%0h expected 1/a1/0", outStValid, outStTag, outStErr); end
    @(negedge clk);
    checks++; if (outStValid !== 1'b0 || sReady !== 1'b1) begin errors++; $display("[TB] FAIL single_back_idle: got v=%0b ready=%0b expected 0/1", outStValid, sReady); end
  endtask

  task automatic test_boundary();
    applyDesc(64'h0F00, 2'd2, 16'hFFF0, 16'h0300, 8'hB2);
    checks++; if (mValid !== 1'b1 || mAddr !== 64'h0F00 || mLen !== 16'h0100 || mRamAddr !== 16'hFFF0 || mTag !== 4'd0 || mRamSel !== 2'd2) begin errors++; $display("[TB] FAIL bnd_chunk0: got v=%0b addr=%0h len=%0h ram=%0h tag=%0h expected 1/f00/100/fff0/0", mValid, mAddr, mLen, mRamAddr, mTag); end
    @(negedge clk);
    checks++; if (mValid !== 1'b1 || mAddr !== 64'h0F00 || mLen !== 16'h0100) begin errors++; $display("[TB] FAIL bnd_hold: got v=%0b addr=%0h len=%0h expected 1/f00/100", mValid, mAddr, mLen); end
    mReady = 1'b1;
    @(negedge clk);
    checks++; if (mValid !== 1'b1 || mAddr !== 64'h1000 || mLen !== 16'h0200 || mRamAddr !== 16'h00F0 || mTag !== 4'd1) begin errors++; $display("[TB] FAIL bnd_chunk1: got v=%0b addr=%0h len=%0h ram=%0h tag=%0h expected 1/1000/200/f0/1", mValid, mAddr, mLen, mRamAddr, mTag); end
    // First completion lands in the same cycle as the final chunk handshake.
    applyStatus(4'd0);
    mReady = 1'b0;
    checks++; if (mValid !== 1'b0 || outStValid !== 1'b0) begin errors++; $display("[TB] FAIL bnd_wait: got v=%0b st=%0b expected 0/0", mValid, outStValid); end
    applyStatus(4'd0);
    checks++; if (outStValid !== 1'b0) begin errors++; $display("[TB] FAIL bnd_early_status: got %0b expected 0", outStValid); end
    @(negedge clk);
    checks++; if (outStValid !== 1'b1 || outStTag !== 8'hB2 || outStErr !== 4'd0) begin errors++; $display("[TB] FAIL bnd_status: got v=%0b tag=%0h err=%0h expected 1/b2/0", outStValid, outStTag, outStErr); end
    @(negedge clk);
  endtask

  task automatic test_outstanding();
    logic [63:0] base;
    base = 64'h1_0000_0000;
    applyDesc(base, 2'd0, 16'h0000, 16'hA000, 8'hC3);
    mReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (mValid !== 1'b1 || mTag !== k[3:0] || mAddr !== base + 64'(k) * 64'd4096 || mLen !== 16'd4096) begin errors++; $display("[TB] FAIL out_chunk%0d: got v=%0b tag=%0h addr=%0h len=%0h expected 1/%0h/%0h/1000", k, mValid, mTag, mAddr, mLen, k, base + 64'(k) * 64'd4096); end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL out_full%0d: got v=%0b expected 0", k, mValid); end
      @(negedge clk);
    end
    applyStatus(4'd0);
    checks++; if (mValid !== 1'b1 || mTag !== 4'd8 || mAddr !== base + 64'h8000) begin errors++; $display("[TB] FAIL out_resume8: got v=%0b tag=%0h addr=%0h expected 1/8/%0h", mValid, mTag, mAddr, base + 64'h8000); end
    @(negedge clk);
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL out_full_again: got v=%0b expected 0", mValid); end
    applyStatus(4'd0);
    checks++; if (mValid !== 1'b1 || mTag !== 4'd9 || mAddr !== base + 64'h9000) begin errors++; $display("[TB] FAIL out_resume9: got v=%0b tag=%0h addr=%0h expected 1/9/%0h", mValid, mTag, mAddr, base + 64'h9000); end
    @(negedge clk);
    mReady = 1'b0;
    checks++; if (mValid !== 1'b0) begin errors++; $display("[TB] FAIL out_last_done: got v=%0b expected 0", mValid); end
    for (int k = 0; k < 8; k++) begin
      applyStatus(4'd0);
      checks++; if (outStValid !== 1'b0) begin errors++; $display("[TB] FAIL out_early_status%0d: got %0b expected 0", k, outStValid); end
    end
    @(negedge clk);
    checks++; if (outStValid !== 1'b1 || outStTag !== 8'hC3 || outStErr !== 4'd0) begin errors++; $display("[TB] FAIL out_status: got v=%0b tag=%0h err=%0h expected 1/c3/0", outStValid, outStTag, outStErr); end
    @(negedge clk);
  endtask

  task automatic test_error_merge();
    int pulses;
    logic [63:0] expAddr [3];
    logic [15:0] expLen [3];
    expAddr[0] = 64'h0800; expAddr[1] = 64'h1000; expAddr[2] = 64'h2000;
    expLen[0]  = 16'h0800; expLen[1]  = 16'h1000; expLen[2]  = 16'h0800;
    applyDesc(64'h0800, 2'd3, 16'h2000, 16'h2000, 8'hD4);
    mReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (mValid !== 1'b1 || mAddr !== expAddr[k] || mLen !== expLen[k]) begin errors++; $display("[TB] FAIL err_chunk%0d: got v=%0b addr=%0h len=%0h expected 1/%0h/%0h", k, mValid, mAddr, mLen, expAddr[k], expLen[k]); end
      @(negedge clk);
    end
    mReady = 1'b0;
    applyStatus(4'd0);
    applyStatus(4'd3);
    applyStatus(4'd5);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (outStValid === 1'b1) begin
        pulses++;
        checks++; if (outStErr !== 4'd3 || outStTag !== 8'hD4) begin errors++; $display("[TB] FAIL err_status: got err=%0h tag=%0h expected 3/d4", outStErr, outStTag); end
      end
      @(negedge clk);
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL err_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_zero_len();
    applyDesc(64'h2000, 2'd0, 16'h0000, 16'h0000, 8'h5A);
    checks++; if (outStValid !== 1'b1 || outStTag !== 8'h5A || outStErr !== 4'd0 || mValid !== 1'b0) begin errors++; $display("[TB] FAIL zero_status: got st=%0b tag=%0h err=%0h mv=%0b expected 1/5a/0/0", outStValid, outStTag, outStErr, mValid); end
    @(negedge clk);
    checks++; if (outStValid !== 1'b0 || sReady !== 1'b1 || mValid !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle: got st=%0b ready=%0b mv=%0b expected 0/1/0", outStValid, sReady, mValid); end
  endtask

  task automatic test_reset_mid();
    int waitCycles;
    applyDesc(64'h0F00, 2'd1, 16'h0010, 16'h0300, 8'h66);
    mReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mReady = 1'b0;
    checks++; if (mValid !== 1'b0 || mTag !== 4'd2) begin errors++; $display("[TB] FAIL mid_wait: got v=%0b tag=%0h expected 0/2", mValid, mTag); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sReady !== 1'b0 || mValid !== 1'b0 || outStValid !== 1'b0 || mAddr !== 64'd0 || mLen !== 16'd0 || mTag !== 4'd0 || outStTag !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got ready=%0b mv=%0b st=%0b addr=%0h len=%0h tag=%0h sttag=%0h expected all 0", sReady, mValid, outStValid, mAddr, mLen, mTag, outStTag); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready: got %0b expected 1", sReady); end
    applyStatus(4'h7);
    applyStatus(4'h7);
    for (int k = 0; k < 3; k++) begin
      checks++; if (outStValid !== 1'b0 || sReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_stale%0d: got st=%0b ready=%0b expected 0/1", k, outStValid, sReady); end
      @(negedge clk);
    end
    applyDesc(64'h4000, 2'd0, 16'h0000, 16'h0040, 8'h67);
    checks++; if (mValid !== 1'b1 || mLen !== 16'h0040 || mAddr !== 64'h4000) begin errors++; $display("[TB] FAIL mid_new_chunk: got v=%0b len=%0h addr=%0h expected 1/40/4000", mValid, mLen, mAddr); end
    mReady = 1'b1;
    @(negedge clk);
    mReady = 1'b0;
    applyStatus(4'd0);
    waitCycles = 0;
    while (outStValid !== 1'b1 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++; if (outStValid !== 1'b1 || outStTag !== 8'h67 || outStErr !== 4'd0) begin errors++; $display("[TB] FAIL mid_new_status: got v=%0b tag=%0h err=%0h expected 1/67/0", outStValid, outStTag, outStErr); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting dma_if_desc_split_rd bench");
    test_reset();
    test_single_chunk();
    test_boundary();
    test_outstanding();
    test_error_merge();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
